// File: rtl/period_meter_pkg.sv
// period_meter_pkg: shared FSM state type and synchronizer depth for period_meter.
package period_meter_pkg;
   typedef enum logic [1:0] {IDLE, ARM, MEASURE, HOLD} state_t;
   localparam int SYNC_STAGES = 2;
endpackage

// File: rtl/sync_edge.sv
// sync_edge: multi-flop synchronizer for an async input plus rising-edge detect.
module sync_edge
   import period_meter_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic level,
   output logic rise
);
   logic [SYNC_STAGES-1:0] sr;
   logic                   level_d;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         sr      <= '0;
         level_d <= 1'b0;
      end else begin
         sr      <= {sr[SYNC_STAGES-2:0], d};
         level_d <= sr[SYNC_STAGES-1];
      end
   assign level = sr[SYNC_STAGES-1];
   assign rise  = level & ~level_d;
endmodule

// File: rtl/period_meter.sv
// period_meter: measures period and high time of a slow async square wave in clk cycles,
// one request per start, result over valid/ready with timeout on a stalled input.
module period_meter
   import period_meter_pkg::*;
#(
   parameter int unsigned          WIDTH   = 32,
   parameter logic [WIDTH-1:0]     TIMEOUT = WIDTH'(100000000)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clk_in,
   input  logic             start,
   output logic             busy,
   output logic             meas_valid,
   input  logic             meas_ready,
   output logic [WIDTH-1:0] period,
   output logic [WIDTH-1:0] high_time,
   output logic             timeout
);
   localparam logic [WIDTH-1:0] LAST = TIMEOUT - WIDTH'(1);
   state_t           state;
   logic [WIDTH-1:0] cnt;
   logic [WIDTH-1:0] hcnt;
   logic             level;
   logic             rise;
   sync_edge u_sync (.clk(clk), .rst_n(rst_n), .d(clk_in), .level(level), .rise(rise));
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state      <= IDLE;
         cnt        <= '0;
         hcnt       <= '0;
         busy       <= 1'b0;
         meas_valid <= 1'b0;
         period     <= '0;
         high_time  <= '0;
         timeout    <= 1'b0;
      end else begin
         case (state)
            IDLE:
               if (start) begin
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= ARM;
               end
            ARM, MEASURE:
               // an edge beats a simultaneous timeout
               if (rise && state == ARM) begin
                  cnt   <= WIDTH'(1);
                  hcnt  <= WIDTH'(1);
                  state <= MEASURE;
               end else if (rise) begin
                  period     <= cnt;
                  high_time  <= hcnt;
                  timeout    <= 1'b0;
                  busy       <= 1'b0;
                  meas_valid <= 1'b1;
                  state      <= HOLD;
               end else if (cnt == LAST) begin
                  period     <= '0;
                  high_time  <= '0;
                  timeout    <= 1'b1;
                  busy       <= 1'b0;
                  meas_valid <= 1'b1;
                  state      <= HOLD;
               end else begin
                  cnt  <= cnt + WIDTH'(1);
                  hcnt <= level ? hcnt + WIDTH'(1) : hcnt;
               end
            HOLD:
               if (meas_ready) begin
                  meas_valid <= 1'b0;
                  state      <= IDLE;
               end
            default: state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_period_meter.sv
// tb_period_meter: directed self-checking bench for period_meter.
module tb_period_meter;
   localparam int W = 16;
   localparam int T = 50;
   logic         clk = 1'b0;
   logic         rst_n;
   logic         clk_in;
   logic         start;
   logic         busy;
   logic         meas_valid;
   logic         meas_ready;
   logic [W-1:0] period;
   logic [W-1:0] high_time;
   logic         timeout;
   logic         wave_en;
   int           hi, lo;
   int           checks = 0;
   int           errors = 0;
   period_meter #(.WIDTH(W), .TIMEOUT(W'(T))) dut (
      .clk(clk), .rst_n(rst_n), .clk_in(clk_in), .start(start), .busy(busy),
      .meas_valid(meas_valid), .meas_ready(meas_ready), .period(period),
      .high_time(high_time), .timeout(timeout)
   );
   always #5 clk = ~clk;
   // square wave aligned to clk falling edges, always starting with the high phase
   initial begin
      clk_in = 1'b0;
      forever begin
         if (wave_en) begin
            clk_in = 1'b1;
            repeat (hi) @(negedge clk);
            clk_in = 1'b0;
            repeat (lo) @(negedge clk);
         end else @(negedge clk);
      end
   end
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d exp %0d", tag, got, exp);
      end
   endtask
   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask
   task automatic wait_valid(input string tag);
      int n = 0;
      while (!meas_valid && n < 200) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_wait"}, 32'(n < 200), 1);
   endtask
   task automatic quiet_wave(input int h, input int l);
      wave_en = 1'b0;
      repeat (30) @(negedge clk);
      hi = h;
      lo = l;
   endtask
   task automatic measure(input string tag, input int h, input int l, input int ep, input int eh);
      quiet_wave(h, l);
      pulse_start();
      check({tag, "_busy"}, 32'(busy), 1);
      wave_en = 1'b1;
      wait_valid(tag);
      check({tag, "_period"}, 32'(period), ep);
      check({tag, "_high"}, 32'(high_time), eh);
      check({tag, "_to"}, 32'(timeout), 0);
      if (meas_ready) begin
         @(negedge clk);
         check({tag, "_vfall"}, 32'(meas_valid), 0);
         check({tag, "_idle"}, 32'(busy), 0);
      end
   endtask
   initial begin
      int n;
      int extra;
      rst_n = 1'b0;
      start = 1'b0;
      meas_ready = 1'b1;
      wave_en = 1'b0;
      hi = 5;
      lo = 5;
      repeat (3) @(negedge clk);
      check("rst_busy", 32'(busy), 0);
      check("rst_valid", 32'(meas_valid), 0);
      check("rst_period", 32'(period), 0);
      check("rst_high", 32'(high_time), 0);
      check("rst_to", 32'(timeout), 0);
      rst_n = 1'b1;
      @(negedge clk);
      measure("sq55", 5, 5, 10, 5);
      measure("sq37", 3, 7, 10, 3);
      measure("sq1212", 12, 12, 24, 12);
      // timeout with clk_in stuck low
      quiet_wave(5, 5);
      start = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         start = 1'b0;
         n++;
      end while (!meas_valid && n < 200);
      check("to_latency", n, T + 1);
      check("to_flag", 32'(timeout), 1);
      check("to_period", 32'(period), 0);
      check("to_high", 32'(high_time), 0);
      @(negedge clk);
      check("to_vfall", 32'(meas_valid), 0);
      // back-pressure: result must stay put while ready is low
      meas_ready = 1'b0;
      measure("hold", 4, 6, 10, 4);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("hold_valid", 32'(meas_valid), 1);
         check("hold_period", 32'(period), 10);
         check("hold_high", 32'(high_time), 4);
      end
      meas_ready = 1'b1;
      check("hs_valid", 32'(meas_valid), 1);
      @(negedge clk);
      check("hs_vfall", 32'(meas_valid), 0);
      check("hs_keep", 32'(period), 10);
      // start during MEASURE is dropped, not queued
      quiet_wave(6, 6);
      pulse_start();
      wave_en = 1'b1;
      repeat (6) @(negedge clk);
      pulse_start();
      wait_valid("dup");
      check("dup_period", 32'(period), 12);
      check("dup_high", 32'(high_time), 6);
      extra = 0;
      repeat (80) begin
         @(negedge clk);
         if (meas_valid) extra++;
      end
      check("dup_extra", extra, 0);
      check("dup_busy", 32'(busy), 0);
      // async reset mid-measurement
      quiet_wave(7, 5);
      pulse_start();
      wave_en = 1'b1;
      repeat (8) @(negedge clk);
      check("mid_busy", 32'(busy), 1);
      rst_n = 1'b0;
      #1;
      check("ar_busy", 32'(busy), 0);
      check("ar_valid", 32'(meas_valid), 0);
      check("ar_period", 32'(period), 0);
      check("ar_high", 32'(high_time), 0);
      check("ar_to", 32'(timeout), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      measure("post", 7, 5, 12, 7);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/period_meter.md
# period_meter

Measures the period and high time of a slow, asynchronous square wave (a divided clock or tick, up to one toggle per several `clk` cycles) in units of `clk` cycles. This is the receive-side counterpart to the team's clock dividers: it closes the loop in self-test and bring-up by checking that a generated clock has the intended frequency and duty cycle. Each measurement is started by a single-cycle request. The result is returned over a valid/ready handshake, and a timeout flags a stalled input.

## Interface
- `WIDTH`, default 32: width of the cycle counters and result buses.
- `TIMEOUT`, default 100000000: cycles allowed without a rising edge before the measurement aborts. Legal range is 2 .. 2^WIDTH−1.
- `clk` input, 1 bit: the single system clock. All logic is on its rising edge.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `clk_in` input, 1 bit: the signal under measurement. It is asynchronous to `clk`.
- `start` input, 1 bit: one-cycle request. It is honoured only in IDLE.
- `busy` output, 1 bit: high in ARM and MEASURE.
- `meas_valid` output, 1 bit: result available.
- `meas_ready` input, 1 bit: consumer accepts the result.
- `period` output, WIDTH bits: `clk` cycles between two consecutive rising edges.
- `high_time` output, WIDTH bits: `clk` cycles in that period during which the synchronized input was high.
- `timeout` output, 1 bit: the result is a timeout, not a measurement.

## Operation
- `clk_in` passes through a 2-flop synchronizer. A rising edge (`edge`) is `sync & ~sync_d`, where `sync_d` is `sync` delayed by one cycle.
- FSM states are IDLE, ARM, MEASURE and HOLD.
- **IDLE**
  - If `start` is high: `cnt`←0, go to ARM.
- **ARM**
  - On `edge`: `cnt`←1, `hcnt`←1, go to MEASURE.
  - Otherwise, if `cnt`==TIMEOUT−1: go to HOLD with `timeout`=1, `period`=0, `high_time`=0.
  - Otherwise: `cnt`++.
- **MEASURE**
  - On `edge`: `period`←`cnt`, `high_time`←`hcnt`, `timeout`←0, go to HOLD.
  - Otherwise, if `cnt`==TIMEOUT−1: timeout exit, identical to ARM's.
  - Otherwise: `cnt`++, and `hcnt`++ if `sync`.
- **HOLD**
  - `meas_valid`=1.
  - When `meas_ready` is high: go to IDLE, and `meas_valid` falls on the next cycle.
- An edge and the timeout condition in the same cycle: the edge wins.
- `start` outside IDLE is ignored and is not queued.
- `period`, `high_time` and `timeout` keep their last values after the handshake. They change only when entering HOLD.
- The counters never wrap, because TIMEOUT ≤ 2^WIDTH−1 bounds them.

## Timing
- Reset values: state IDLE, `busy`=0, `meas_valid`=0, `period`=0, `high_time`=0, `timeout`=0, synchronizer flops 0.
- `rst_n` asserted mid-measurement aborts the measurement immediately, and all outputs return to their reset values.
- A `clk_in` rise is seen as `edge` 2–3 `clk` cycles later. This latency is the same for both edges, so it cancels out of `period`.
- `busy` rises 1 cycle after `start` is sampled.
- `meas_valid` rises 1 cycle after the terminating edge or timeout is detected.
- Timeout from ARM: `meas_valid` rises TIMEOUT+1 cycles after the `start` cycle.
- While `meas_valid`=1 and `meas_ready`=0, all outputs are held stable for any number of cycles.
- Minimum accepted `clk_in` high and low times are 2 `clk` cycles each. Narrower pulses may be missed, and that is acceptable.

## Structure
- Package `period_meter_pkg` holds:
  - the `state_t` enum (IDLE, ARM, MEASURE, HOLD);
  - the localparam `SYNC_STAGES`=2.
- Sub-module `sync_edge` contains the synchronizer plus rising-edge detector. It has inputs `clk`, `rst_n`, `d`, and outputs `level` and `rise`.
- The top level contains only the FSM, the counters and the output registers.

## Test plan
- Square wave high 5 / low 5, `meas_ready` tied to 1, `start` pulse → one result with `period`=10, `high_time`=5, `timeout`=0; `busy` is low afterwards.
- Input high 3 / low 7 → `period`=10, `high_time`=3. Then a second measurement on a 12/12 wave → `period`=24, `high_time`=12.
- `clk_in` held at 0, TIMEOUT=50 → `meas_valid` rises 51 cycles after `start`, with `timeout`=1, `period`=0, `high_time`=0.
- Result ready and `meas_ready` held low for 20 cycles → `meas_valid` and the data stay stable for all 20 cycles. One cycle of ready → `meas_valid` falls on the next cycle.
- `start` pulsed again during MEASURE → ignored; exactly one result is produced, and it is correct.
- `rst_n` pulsed low during MEASURE → all outputs go to 0 immediately. After release, a fresh `start` yields a correct result.
